hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage LEGv8 core. It watches the

---
 rtl/hazard_stall_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage LEGv8 core: load-use stalls,
// branch flushes, data-memory wait/timeout handling and stall/flush counters.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic [31:0]      instruction_ID,
    input  logic [4:0]       RD_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             flush_younger,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    logic [10:0] opc;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic        use_rn;
    logic        use_rm;
    logic        use_rt;
    logic        load_use;
    logic        unused_bits;

    assign opc         = instruction_ID[31:21];
    assign rm          = instruction_ID[20:16];
    assign rn          = instruction_ID[9:5];
    assign rt          = instruction_ID[4:0];
    assign unused_bits = ^instruction_ID[15:10];

    always_comb begin
        use_rn = 1'b0;
        use_rm = 1'b0;
        use_rt = 1'b0;
        if (opc == OP_ADD || opc == OP_SUB || opc == OP_AND || opc == OP_ORR) begin
            use_rn = 1'b1;
            use_rm = 1'b1;
        end else if (opc == OP_LDUR) begin
            use_rn = 1'b1;
        end else if (opc == OP_STUR) begin
            use_rn = 1'b1;
            use_rt = 1'b1;
        end else if (instruction_ID[31:24] == OP_CBZ) begin
            use_rt = 1'b1;
        end
    end

    // X31 is the zero register, so a load targeting it never creates a hazard.
    assign load_use = MemRead_EX && (RD_EX != 5'd31) &&
                      ((use_rn && rn == RD_EX) ||
                       (use_rm && rm == RD_EX) ||
                       (use_rt && rt == RD_EX));

    always_comb begin
        next_state    = state;
        wait_nxt      = wait_cnt;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        exmem_write   = 1'b1;
        idex_bubble   = 1'b0;
        memwb_bubble  = 1'b0;
        flush_younger = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    flush_younger = 1'b1;
                end else if (dmem_req && !dmem_ready) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    next_state   = ST_MEM_WAIT;
                    wait_nxt     = WAIT_W'(1);
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    next_state = ST_RUN;
                    wait_nxt   = '0;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        next_state = ST_ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
            end
            default: begin
                next_state = ST_RUN;
                wait_nxt   = '0;
            end
        endcase
        // Hold the pipeline in its plain advancing form while reset is asserted.
        if (!resetl) begin
            pc_write      = 1'b1;
            ifid_write    = 1'b1;
            idex_write    = 1'b1;
            exmem_write   = 1'b1;
            idex_bubble   = 1'b0;
            memwb_bubble  = 1'b0;
            flush_younger = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err | (next_state == ST_ERROR);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_younger && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, multi-cycle
// corner sequences and random traffic against a behavioural reference model.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int SAT     = (1 << CW) - 1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble, flush_younger}
    localparam logic [6:0] NORMAL  = 7'b1111000;
    localparam logic [6:0] LUSTALL = 7'b0011100;
    localparam logic [6:0] FLUSH   = 7'b1111001;
    localparam logic [6:0] FROZEN  = 7'b0000010;
    localparam logic [6:0] ERRPAT  = 7'b0000110;

    logic          clk = 1'b0;
    logic          resetl;
    logic [31:0]   instruction_ID;
    logic [4:0]    RD_EX;
    logic          MemRead_EX, branch_taken, dmem_req, dmem_ready, cnt_clr;
    logic          pc_write, ifid_write, idex_write, exmem_write;
    logic          idex_bubble, memwb_bubble, flush_younger, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    outs;

    int compared   = 0;
    int mismatched = 0;

    int m_mode;
    int m_waited;
    bit m_err;
    int m_stall;
    int m_flush;

    typedef struct {
        int n;
        int r0;
        int r1;
    } src_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        mr;
        logic        br;
        logic        req;
        logic        rdy;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                   idex_bubble, memwb_bubble, flush_younger};

    hazard_stall_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk            (clk),
        .resetl         (resetl),
        .instruction_ID (instruction_ID),
        .RD_EX          (RD_EX),
        .MemRead_EX     (MemRead_EX),
        .branch_taken   (branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .cnt_clr        (cnt_clr),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .idex_write     (idex_write),
        .exmem_write    (exmem_write),
        .idex_bubble    (idex_bubble),
        .memwb_bubble   (memwb_bubble),
        .flush_younger  (flush_younger),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // A taken branch never touches data memory, so the two never coincide.
    always @(posedge clk) begin
        if (resetl) begin
            assert (!(branch_taken && dmem_req))
                else $error("[TB] illegal stimulus: branch_taken with dmem_req");
        end
    end

    function automatic logic [31:0] encR(input logic [10:0] opc, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm);
        return {opc, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] encD(input logic [10:0] opc, input logic [4:0] rt,
                                         input logic [4:0] rn);
        return {opc, 9'd16, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] encCbz(input logic [4:0] rt);
        return {8'b10110100, 19'd4, rt};
    endfunction

    function automatic logic [31:0] encB();
        return {6'b000101, 26'd8};
    endfunction

    function automatic src_t sourcesOf(input logic [31:0] ins);
        src_t s;
        s.n  = 0;
        s.r0 = 0;
        s.r1 = 0;
        if (ins[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            s.n = 2; s.r0 = int'(ins[9:5]); s.r1 = int'(ins[20:16]);
        end else if (ins[31:21] == OP_LDUR) begin
            s.n = 1; s.r0 = int'(ins[9:5]);
        end else if (ins[31:21] == OP_STUR) begin
            s.n = 2; s.r0 = int'(ins[9:5]); s.r1 = int'(ins[4:0]);
        end else if (ins[31:24] == 8'b10110100) begin
            s.n = 1; s.r0 = int'(ins[4:0]);
        end
        return s;
    endfunction

    function automatic bit hazardModel(input logic [31:0] ins, input logic [4:0] rd,
                                       input logic mr);
        src_t s;
        int   r;
        if (!mr || rd == 5'd31) return 1'b0;
        s = sourcesOf(ins);
        for (int i = 0; i < s.n; i++) begin
            r = (i == 0) ? s.r0 : s.r1;
            if (r == int'(rd)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [4:0] rd, input logic mr,
                                 input logic br, input logic req, input logic rdy,
                                 input logic clr, input logic rst_n);
        @(negedge clk);
        instruction_ID = ins;
        RD_EX          = rd;
        MemRead_EX     = mr;
        branch_taken   = br;
        dmem_req       = req;
        dmem_ready     = rdy;
        cnt_clr        = clr;
        resetl         = rst_n;
        #1;
    endtask

    // Reference model: compares this cycle's outputs, then advances to the next cycle.
    task automatic modelStep(input string tag);
        logic [6:0] e;
        if (!resetl) begin
            m_mode = 0; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
            e = NORMAL;
        end else begin
            case (m_mode)
                0: begin
                    if (branch_taken)                e = FLUSH;
                    else if (dmem_req && !dmem_ready) e = FROZEN;
                    else if (hazardModel(instruction_ID, RD_EX, MemRead_EX)) e = LUSTALL;
                    else                              e = NORMAL;
                end
                1:       e = dmem_ready ? NORMAL : FROZEN;
                default: e = ERRPAT;
            endcase
        end
        checkOutput({tag, ".ctl"}, 32'(outs), 32'(e));
        checkOutput({tag, ".mem_err"}, 32'(mem_err), 32'(m_err));
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        if (resetl) begin
            if (cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (!e[6] && m_stall < SAT) m_stall++;
                if (e[0] && m_flush < SAT)  m_flush++;
            end
            if (m_mode == 0) begin
                if (!branch_taken && dmem_req && !dmem_ready) begin
                    m_mode   = 1;
                    m_waited = 1;
                end
            end else if (m_mode == 1) begin
                if (dmem_ready) begin
                    m_mode = 0;
                end else begin
                    m_waited++;
                    if (m_waited >= TIMEOUT) begin
                        m_mode = 2;
                        m_err  = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        modelStep(tag);
    endtask

    task automatic resetPulse();
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelStep("rst");
    endtask

    function automatic logic [4:0] pickReg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    function automatic logic [31:0] randInstr();
        case ($urandom_range(0, 8))
            0:       return encR(OP_ADD, pickReg(), pickReg(), pickReg());
            1:       return encR(OP_SUB, pickReg(), pickReg(), pickReg());
            2:       return encR(OP_AND, pickReg(), pickReg(), pickReg());
            3:       return encR(OP_ORR, pickReg(), pickReg(), pickReg());
            4:       return encD(OP_LDUR, pickReg(), pickReg());
            5:       return encD(OP_STUR, pickReg(), pickReg());
            6:       return encCbz(pickReg());
            7:       return encB();
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic        br;
        logic        req;

        vecs[0]  = '{encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LUSTALL};
        vecs[1]  = '{encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[2]  = '{encB(),                          5'd9,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[3]  = '{encD(OP_STUR, 5'd9, 5'd1),       5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LUSTALL};
        vecs[4]  = '{encD(OP_STUR, 5'd2, 5'd9),       5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LUSTALL};
        vecs[5]  = '{encD(OP_LDUR, 5'd9, 5'd2),       5'd9,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[6]  = '{encCbz(5'd9),                    5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LUSTALL};
        vecs[7]  = '{encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9,  1'b0, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[8]  = '{encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[9]  = '{encR(OP_SUB, 5'd3, 5'd1, 5'd9),  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, LUSTALL};
        vecs[10] = '{encR(OP_ORR, 5'd3, 5'd1, 5'd2),  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[11] = '{encR(OP_AND, 5'd3, 5'd1, 5'd2),  5'd9,  1'b0, 1'b0, 1'b1, 1'b1, NORMAL};
        vecs[12] = '{32'h0009_0129,                   5'd9,  1'b1, 1'b0, 1'b0, 1'b0, NORMAL};
        vecs[13] = '{encCbz(5'd9),                    5'd9,  1'b1, 1'b0, 1'b1, 1'b1, LUSTALL};

        resetPulse();
        checkOutput("reset.outs", 32'(outs), 32'(NORMAL));

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].rd, vecs[i].mr, vecs[i].br,
                          vecs[i].req, vecs[i].rdy, 1'b0, 1'b1);
            checkOutput($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
            modelStep($sformatf("vec%0d", i));
        end

        // Single load-use stall counts exactly one stalled cycle.
        resetPulse();
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        modelStep("t1");
        applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1.stall_cnt", 32'(stall_cnt), 32'd1);
        modelStep("t1b");

        // Branch wins over a simultaneous load-use hazard.
        resetPulse();
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.outs", 32'(outs), 32'(FLUSH));
        modelStep("t3");
        applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3.flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("t3.stall_cnt", 32'(stall_cnt), 32'd0);
        modelStep("t3b");

        // Three cycles of memory wait, then completion.
        resetPulse();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("t4.frozen%0d", i), 32'(outs), 32'(FROZEN));
            modelStep("t4");
        end
        applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4.advance", 32'(outs), 32'(NORMAL));
        modelStep("t4r");
        idleStep("t4i");
        checkOutput("t4.stall_cnt", 32'(stall_cnt), 32'd3);

        // Memory timeout: four frozen cycles, then sticky ERROR until reset.
        resetPulse();
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("t5.frozen%0d", i), 32'(outs), 32'(FROZEN));
            modelStep("t5");
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("t5.error%0d", i), 32'(outs), 32'(ERRPAT));
            checkOutput($sformatf("t5.mem_err%0d", i), 32'(mem_err), 32'd1);
            modelStep("t5e");
        end
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5.rst_outs", 32'(outs), 32'(NORMAL));
        checkOutput("t5.rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("t5.rst_stall", 32'(stall_cnt), 32'd0);
        modelStep("t5rst");
        applyStimulus(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t5.run", 32'(outs), 32'(NORMAL));
        modelStep("t5run");

        // Counter saturation and clear-over-increment.
        resetPulse();
        for (int i = 0; i < SAT + 5; i++) begin
            applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            modelStep("t6");
        end
        checkOutput("t6.stall_sat", 32'(stall_cnt), 32'(SAT));
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        modelStep("t6clr");
        applyStimulus(encR(OP_ADD, 5'd10, 5'd9, 5'd9), 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6.stall_cleared", 32'(stall_cnt), 32'd0);
        modelStep("t6b");
        for (int i = 0; i < SAT + 3; i++) begin
            applyStimulus(encB(), 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            modelStep("t6f");
        end
        idleStep("t6i");
        checkOutput("t6.flush_sat", 32'(flush_cnt), 32'(SAT));

        // Random traffic against the model, with periodic resets.
        resetPulse();
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) begin
                resetPulse();
            end else begin
                ins = randInstr();
                br  = ($urandom_range(0, 9) < 2);
                req = br ? 1'b0 : ($urandom_range(0, 9) < 3);
                applyStimulus(ins, pickReg(), 1'($urandom_range(0, 1)), br, req,
                              ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), 1'b1);
                modelStep($sformatf("rnd%0d", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
